// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues request-to-send,
// shifts out one odd-parity command frame on device clock edges and checks the ack.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    SHIFT,
    ACK,
    RELEASE
  } state_t;

  state_t           state;
  logic [1:0]       clk_sync;
  logic [1:0]       data_sync;
  logic             clk_prev;
  logic             fe;
  logic [9:0]       frame;
  logic [3:0]       bit_idx;
  logic [INH_W-1:0] inh_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic             nack;

  // NOTE: sequential state is written with non-blocking assignments only, so every
  // register samples the pre-edge value of every other register regardless of order.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk_in};
      data_sync <= {data_sync[0], ps2_data_in};
      clk_prev  <= clk_sync[1];
    end
  end

  assign fe       = clk_prev & ~clk_sync[1];
  assign tx_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      frame       <= '0;
      bit_idx     <= '0;
      inh_cnt     <= '0;
      tmo_cnt     <= '0;
      nack        <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;

      case (state)
        IDLE: begin
          if (tx_valid) begin
            frame      <= {1'b1, ~^tx_data, tx_data};
            inh_cnt    <= '0;
            ps2_clk_oe <= 1'b1;
            busy       <= 1'b1;
            state      <= INHIBIT;
          end
        end
        INHIBIT: begin
          if (inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b1;
            tmo_cnt     <= '0;
            state       <= RTS;
          end else begin
            inh_cnt <= inh_cnt + 1'b1;
          end
        end
        RTS: begin
          if (fe) begin
            bit_idx <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (fe) begin
            ps2_data_oe <= ~frame[bit_idx];
            bit_idx     <= bit_idx + 1'b1;
            if (bit_idx == 4'd9) state <= ACK;
          end
        end
        ACK: begin
          if (fe) begin
            nack  <= data_sync[1];
            state <= RELEASE;
          end
        end
        RELEASE: begin
          if (clk_sync[1] && data_sync[1]) begin
            done  <= ~nack;
            err   <= nack;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // tmo_cnt holds cycles elapsed since the last device edge (the fe cycle is 0);
      // an abort overrides whatever the state machine decided this cycle.
      if (state inside {RTS, SHIFT, ACK, RELEASE}) begin
        if (fe) begin
          tmo_cnt <= TMO_W'(1);
        end else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          busy        <= 1'b0;
          done        <= 1'b0;
          err         <= 1'b1;
          state       <= IDLE;
        end else begin
          tmo_cnt <= tmo_cnt + 1'b1;
        end
      end
    end
  end

endmodule
